// File: rtl/ws2812_rx.sv
// ---------------------------------------------------------------------------
// ws2812_rx
// Receiver/decoder for the WS2812 single-wire LED protocol. The data line is
// synchronised, every high pulse is classified as a 0 or 1 by its length, bits
// are assembled MSB-first into 24-bit {G,R,B} pixels, and a complete frame is
// latched to the output when the line stays low for the latch gap.
//
// Ports
//   clk              system clock
//   reset            asynchronous, active-low reset (0 = in reset)
//   ws_data_in       WS2812 data line, asynchronous to clk
//   packed_rgb_data  last latched frame, LED n at [24*n +: 24] as {G,R,B}
//   frame_valid      1-cycle pulse when packed_rgb_data updates
//   pixel_valid      1-cycle pulse per completed pixel
//   pixel_data       {G,R,B} of the pixel just completed
//   pixel_index      index of the pixel just completed (saturates at NUM_LEDS)
//   overflow         sticky: more than NUM_LEDS pixels in the current frame
//   error            sticky: partial pixel at latch or over-long high pulse
//   busy             1 while a frame is in progress
// ---------------------------------------------------------------------------
module ws2812_rx #(
    parameter int NUM_LEDS     = 8,
    parameter int CLK_MHZ      = 12,
    parameter int THRESH_CYC   = CLK_MHZ * 6 / 10,
    parameter int RESET_CYC    = CLK_MHZ * 50,
    parameter int MAX_HIGH_CYC = CLK_MHZ * 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ws_data_in,
    output logic [24*NUM_LEDS-1:0]        packed_rgb_data,
    output logic                          frame_valid,
    output logic                          pixel_valid,
    output logic [23:0]                   pixel_data,
    output logic [$clog2(NUM_LEDS+1)-1:0] pixel_index,
    output logic                          overflow,
    output logic                          error,
    output logic                          busy
);

    localparam int CW = $clog2(RESET_CYC + 1);
    localparam int IW = $clog2(NUM_LEDS + 1);
    localparam int PW = 24 * NUM_LEDS;

    localparam logic [CW-1:0] THRESH_C = CW'(THRESH_CYC);
    localparam logic [CW-1:0] RESET_C  = CW'(RESET_CYC);
    localparam logic [CW-1:0] MAXH_C   = CW'(MAX_HIGH_CYC);
    localparam logic [IW-1:0] NLED_C   = IW'(NUM_LEDS);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    logic sync1_q, sync2_q, sync3_q;

    state_t           state_q, state_d;
    logic [CW-1:0]    hcnt_q, hcnt_d;
    logic [CW-1:0]    lcnt_q, lcnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]    pix_cnt_q, pix_cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [23:0]      pixel_data_q, pixel_data_d;
    logic [IW-1:0]    pixel_index_q, pixel_index_d;
    logic             frame_valid_q, frame_valid_d;
    logic             overflow_q, overflow_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;
    logic [PW-1:0]    packed_q, packed_d;

    // Shadow frame buffer, written pixel by pixel, copied out at latch.
    logic [23:0]      shadow_q [NUM_LEDS];
    logic [23:0]      shadow_d [NUM_LEDS];
    logic [PW-1:0]    shadow_flat;

    logic             rise, fall;
    logic             new_bit;
    logic [23:0]      shifted;
    logic [CW-1:0]    hcnt_inc, lcnt_inc;
    logic             wr_en;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign rise     = sync2_q & ~sync3_q;
    assign fall     = ~sync2_q & sync3_q;
    // hcnt_q holds the number of high cycles seen when the falling edge arrives.
    assign new_bit  = (hcnt_q >= THRESH_C);
    assign shifted  = {shift_q[22:0], new_bit};
    assign hcnt_inc = sat_inc(hcnt_q);
    assign lcnt_inc = sat_inc(lcnt_q);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_shadow
            assign shadow_d[gi] = (wr_en && (pix_cnt_q == IW'(gi))) ? shifted : shadow_q[gi];
            assign shadow_flat[24*gi +: 24] = shadow_q[gi];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        shift_d       = shift_q;
        pixel_valid_d = 1'b0;
        pixel_data_d  = pixel_data_q;
        pixel_index_d = pixel_index_q;
        frame_valid_d = 1'b0;
        overflow_d    = overflow_q;
        error_d       = error_q;
        busy_d        = busy_q;
        packed_d      = packed_q;
        wr_en         = 1'b0;

        case (state_q)
            ST_SYNC: begin
                // Need an unbroken low of RESET_CYC before trusting bit boundaries.
                if (sync2_q) begin
                    lcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= RESET_C) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_IDLE: begin
                // Idle low time is not counted, so an empty gap never latches.
                if (rise) begin
                    state_d    = ST_HIGH;
                    hcnt_d     = CW'(1);
                    busy_d     = 1'b1;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    shift_d = shifted;
                    lcnt_d  = CW'(1);
                    state_d = ST_LOW;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d     = '0;
                        pixel_valid_d = 1'b1;
                        pixel_data_d  = shifted;
                        pixel_index_d = pix_cnt_q;
                        if (pix_cnt_q < NLED_C) begin
                            wr_en = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        if (pix_cnt_q != NLED_C) begin
                            pix_cnt_d = pix_cnt_q + IW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    hcnt_d = hcnt_inc;
                    if (hcnt_inc >= MAXH_C) begin
                        // Stuck-high line: abandon the frame and resynchronise.
                        error_d   = 1'b1;
                        busy_d    = 1'b0;
                        bit_cnt_d = '0;
                        pix_cnt_d = '0;
                        lcnt_d    = '0;
                        state_d   = ST_SYNC;
                    end
                end
            end

            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    hcnt_d  = CW'(1);
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc >= RESET_C) begin
                        state_d = ST_LATCH;
                    end
                end
            end

            ST_LATCH: begin
                packed_d      = shadow_flat;
                frame_valid_d = 1'b1;
                busy_d        = 1'b0;
                if (bit_cnt_q != 5'd0) begin
                    error_d = 1'b1;
                end
                bit_cnt_d = '0;
                pix_cnt_d = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_SYNC;
                lcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            state_q       <= ST_SYNC;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            shift_q       <= '0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            pixel_index_q <= '0;
            frame_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            error_q       <= 1'b0;
            busy_q        <= 1'b0;
            packed_q      <= '0;
        end else begin
            sync1_q       <= ws_data_in;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            shift_q       <= shift_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            pixel_index_q <= pixel_index_d;
            frame_valid_q <= frame_valid_d;
            overflow_q    <= overflow_d;
            error_q       <= error_d;
            busy_q        <= busy_d;
            packed_q      <= packed_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign packed_rgb_data = packed_q;
    assign frame_valid     = frame_valid_q;
    assign pixel_valid     = pixel_valid_q;
    assign pixel_data      = pixel_data_q;
    assign pixel_index     = pixel_index_q;
    assign overflow        = overflow_q;
    assign error           = error_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// ---------------------------------------------------------------------------
// tb_ws2812_rx
// Directed bench for ws2812_rx (NUM_LEDS=8, CLK_MHZ=12). A bit-level encoder
// drives the line (bit 0 = 5H/10L, bit 1 = 10H/5L); each driven pixel pushes
// its expected {data,index} onto a queue that a monitor pops on pixel_valid.
// A local frame model tracks what packed_rgb_data must hold after each latch.
// ---------------------------------------------------------------------------
module tb_ws2812_rx;

    localparam int NUM_LEDS = 8;
    localparam int IW       = $clog2(NUM_LEDS + 1);
    localparam int PW       = 24 * NUM_LEDS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ws_data_in = 1'b0;
    logic [PW-1:0] packed_rgb_data;
    logic          frame_valid;
    logic          pixel_valid;
    logic [23:0]   pixel_data;
    logic [IW-1:0] pixel_index;
    logic          overflow;
    logic          error;
    logic          busy;

    ws2812_rx #(.NUM_LEDS(NUM_LEDS), .CLK_MHZ(12)) dut (
        .clk             (clk),
        .reset           (reset),
        .ws_data_in      (ws_data_in),
        .packed_rgb_data (packed_rgb_data),
        .frame_valid     (frame_valid),
        .pixel_valid     (pixel_valid),
        .pixel_data      (pixel_data),
        .pixel_index     (pixel_index),
        .overflow        (overflow),
        .error           (error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]   data;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] model [NUM_LEDS];
    int          total  = 0;
    int          bad    = 0;
    int          frames = 0;
    int          pixels = 0;
    int          p_mark = 0;
    int          exp_n  = 0;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] model_packed();
        logic [PW-1:0] v;
        for (int i = 0; i < NUM_LEDS; i++) v[24*i +: 24] = model[i];
        return v;
    endfunction

    task automatic drive(input logic lvl, input int n);
        ws_data_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, 10);
            drive(1'b0, 5);
        end else begin
            drive(1'b1, 5);
            drive(1'b0, 10);
        end
    endtask

    // Sends the top nbits of v, MSB first, with no scoreboard entry.
    task automatic send_raw(input logic [23:0] v, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_bit(v[i]);
    endtask

    task automatic send_pixel(input logic [23:0] v);
        exp_t e;
        e.data = v;
        e.idx  = (exp_n < NUM_LEDS) ? IW'(exp_n) : IW'(NUM_LEDS);
        exp_q.push_back(e);
        if (exp_n < NUM_LEDS) model[exp_n] = v;
        exp_n++;
        send_raw(v, 24);
    endtask

    task automatic end_frame(input logic latch, input int npix, input logic err, input logic ovf);
        int f0;
        f0 = frames;
        drive(1'b0, 630);
        check("frame_valid_count", PW'(frames - f0), PW'(latch ? 1 : 0));
        check("pixel_valid_count", PW'(pixels - p_mark), PW'(npix));
        check("scoreboard_empty", PW'(exp_q.size()), '0);
        check("error_after_gap", PW'(error), PW'(err));
        check("overflow_after_gap", PW'(overflow), PW'(ovf));
        check("busy_after_gap", PW'(busy), '0);
        if (latch) check("packed_frame", packed_rgb_data, model_packed());
        $display("frame end: latch=%0d pixels=%0d err=%0d ovf=%0d", latch, pixels - p_mark, error, overflow);
        p_mark = pixels;
        exp_n  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_packed"}, packed_rgb_data, '0);
        check({tag, "_flags"}, PW'({frame_valid, pixel_valid, overflow, error, busy}), '0);
        check({tag, "_pixel"}, PW'({pixel_data, pixel_index}), '0);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (frame_valid) frames++;
            if (pixel_valid) begin
                pixels++;
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL pixel_unexpected observed=%0h/%0d expected=none", pixel_data, pixel_index);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert ({pixel_data, pixel_index} === {e.data, e.idx}) else begin
                        bad++;
                        $error("FAIL pixel observed=%0h/%0d expected=%0h/%0d",
                               pixel_data, pixel_index, e.data, e.idx);
                    end
                    $display("pixel: data=%06h idx=%0d", pixel_data, pixel_index);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] r;
        for (int i = 0; i < NUM_LEDS; i++) model[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        drive(1'b0, 650);

        // 1: single pixel
        send_pixel(24'h102030);
        end_frame(1'b1, 1, 1'b0, 1'b0);

        // 2: full frame of 8 pixels
        for (int i = 1; i <= 8; i++) begin
            send_pixel(24'(i));
            if (i == 3) check("busy_mid_frame", PW'(busy), PW'(1));
        end
        end_frame(1'b1, 8, 1'b0, 1'b0);

        // 3: 9 pixels overflow, next frame clears overflow
        for (int i = 1; i <= 9; i++) send_pixel(24'h100 + 24'(i));
        end_frame(1'b1, 9, 1'b0, 1'b1);
        send_pixel(24'hAABBCC);
        check("overflow_cleared", PW'(overflow), '0);
        end_frame(1'b1, 1, 1'b0, 1'b0);

        // 4: 30 bits -> partial pixel dropped, error, LEDs 1..7 unchanged
        send_pixel(24'h123456);
        send_raw(24'hB00000, 6);
        end_frame(1'b1, 1, 1'b1, 1'b0);

        // 5: over-long high pulse mid-pixel
        send_raw(24'hFFC000, 10);
        check("error_cleared_on_rise", PW'(error), '0);
        drive(1'b1, 70);
        drive(1'b0, 20);
        check("error_long_high", PW'(error), PW'(1));
        check("busy_after_long_high", PW'(busy), '0);
        send_raw(24'hDEADBE, 24);
        end_frame(1'b0, 0, 1'b1, 1'b0);
        send_pixel(24'h0F0F0F);
        end_frame(1'b1, 1, 1'b0, 1'b0);

        // 6: reset mid-pixel, then loopback frame
        send_raw(24'h5A5A5A, 12);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        for (int i = 0; i < NUM_LEDS; i++) model[i] = '0;
        exp_q.delete();
        p_mark = pixels;
        exp_n  = 0;
        send_raw(24'h777777, 24);
        end_frame(1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < NUM_LEDS; i++) begin
            r = 24'($urandom);
            send_pixel(r);
        end
        end_frame(1'b1, 8, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
